// File: rtl/pc_adjust_pkg.sv
// Shared next-PC definitions: datapath width, sequential step and select encodings.
// The decoder and control unit use the same select constants.
package pc_adjust_pkg;
  localparam int WIDTH = 16;
  localparam int INCR  = 1;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_JUMP   = 2'b01;
  localparam logic [1:0] SEL_BRANCH = 2'b10;
  localparam logic [1:0] SEL_HOLD   = 2'b11;
endpackage

// File: rtl/pc_adjust_next.sv
// Combinational next-PC mux/adder. All arithmetic wraps modulo 2^WIDTH.
module pc_adjust_next
  import pc_adjust_pkg::*;
#(
  parameter int W    = WIDTH,
  parameter int STEP = INCR
) (
  input  logic [W-1:0] pc,
  input  logic [W-1:0] jump_addr,
  input  logic [1:0]   sel,
  output logic [W-1:0] next_pc
);
  always_comb begin
    next_pc = 'x;
    case (sel)
      SEL_SEQ:    next_pc = pc + W'(STEP);
      SEL_JUMP:   next_pc = jump_addr;
      // Negative offsets arrive as two's-complement and simply wrap.
      SEL_BRANCH: next_pc = pc + jump_addr;
      SEL_HOLD:   next_pc = pc;
      default:    next_pc = 'x;
    endcase
  end
endmodule

// File: rtl/pc_adjust.sv
// Next-PC selection stage: one-cycle registered result of pc_adjust_next,
// cleared asynchronously by rst_n.
module pc_adjust
  import pc_adjust_pkg::*;
#(
  parameter int WIDTH = pc_adjust_pkg::WIDTH,
  parameter int INCR  = pc_adjust_pkg::INCR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] jumpAddr,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] adjustedPC
);
  logic [WIDTH-1:0] next_pc;

  pc_adjust_next #(.W(WIDTH), .STEP(INCR)) u_next (
    .pc        (PC),
    .jump_addr (jumpAddr),
    .sel       (select),
    .next_pc   (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) adjustedPC <= '0;
    else        adjustedPC <= next_pc;
  end
endmodule

// File: tb/tb_pc_adjust.sv
// Scoreboard bench for pc_adjust: stimulus pushes reference results, a monitor
// pops and compares one cycle later; reset behaviour is checked inline.
module tb_pc_adjust;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] PC = '0;
  logic [15:0] jumpAddr = '0;
  logic [1:0]  select = '0;
  logic [15:0] adjustedPC;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  pc_adjust dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PC         (PC),
    .jumpAddr   (jumpAddr),
    .select     (select),
    .adjustedPC (adjustedPC)
  );

  always #5 clk = ~clk;

  // Reference: the four modes expressed as plain integer arithmetic mod 2^16.
  function automatic logic [15:0] ref_next(input int pc, input int ja, input int sel);
    int r;
    case (sel)
      0:       r = (pc + 1) % 65536;
      1:       r = ja;
      2:       r = (pc + ja) % 65536;
      default: r = pc;
    endcase
    return 16'(r);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] p, input logic [15:0] j, input logic [1:0] s);
    PC = p; jumpAddr = j; select = s;
    exp_q.push_back(ref_next(int'(p), int'(j), int'(s)));
  endtask

  task automatic step(input logic [15:0] p, input logic [15:0] j, input logic [1:0] s);
    @(negedge clk);
    drive(p, j, s);
  endtask

  task automatic drain();
    int budget = 10;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d results pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every edge taken out of reset produces one registered result.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && exp_q.size() != 0) begin
        logic [15:0] exp;
        #1;
        exp = exp_q.pop_front();
        check("scoreboard", adjustedPC, exp);
      end
    end
  end

  initial begin
    PC = 16'h1234; jumpAddr = 16'hBEEF; select = 2'b10;
    #2 rst_n = 1'b0;
    #1 check("reset_immediate", adjustedPC, 16'h0000);
    repeat (3) begin
      @(negedge clk);
      PC = 16'($urandom); jumpAddr = 16'($urandom); select = 2'($urandom);
      check("reset_hold", adjustedPC, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(16'h0080, 16'h8808, 2'b00);          // 0x0081
    step(16'hFFFF, 16'h8808, 2'b00);           // wrap to 0x0000
    step(16'h0080, 16'h8808, 2'b01);           // 0x8808
    step(16'h0080, 16'h8808, 2'b10);           // 0x8888
    step(16'h0080, 16'hFFFE, 2'b10);           // 0x007E
    step(16'h0080, 16'h8808, 2'b11);           // 0x0080
    drain();

    // Select changes between edges: output must not move until the edge.
    @(negedge clk);
    PC = 16'h0080; jumpAddr = 16'h8808; select = 2'b11;
    #2 check("mid_cycle_before", adjustedPC, 16'h0080);
    select = 2'b01;
    exp_q.push_back(ref_next(16'h0080, 16'h8808, 1));
    #1 check("mid_cycle_after", adjustedPC, 16'h0080);
    drain();

    // Reset mid-operation.
    step(16'h0080, 16'h8808, 2'b10);
    drain();
    check("pre_reset", adjustedPC, 16'h8888);
    #1 rst_n = 1'b0;
    #1 check("reset_midop", adjustedPC, 16'h0000);
    repeat (2) begin
      @(negedge clk);
      check("reset_midop_hold", adjustedPC, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(16'h0010, 16'h8808, 2'b00);          // 0x0011
    drain();

    // Randomized run with corner values mixed in.
    for (int i = 0; i < 300; i++) begin
      logic [15:0] p, j;
      p = 16'($urandom);
      j = 16'($urandom);
      if ($urandom_range(0, 7) == 0) p = 16'hFFFF;
      if ($urandom_range(0, 7) == 0) j = 16'hFFFF;
      step(p, j, 2'($urandom));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
